// File: rtl/receiver_cntrlr_pkg.sv
// Shared constants for the UART receive controller: byte width and FSM state codes.
// The core handshake uses the same input_data / input_valid / input_ready names as the transmit side.
package receiver_cntrlr_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    COLLECT = 3'b001,
    STALL   = 3'b010
  } rx_state_e;
endpackage

// File: rtl/rx_timeout_counter.sv
// Saturating inter-byte timer; expired holds while the count sits at TIMEOUT_CYCLES.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (en && cnt != LIMIT) cnt <= cnt + CNT_W'(1);
  end

  // A zero limit disables the timer entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);
endmodule

// File: rtl/receiver_cntrlr.sv
// Assembles UART bytes (LSB first) into WORD_BYTES-byte operands for the core,
// with a one-word stall buffer, overrun flag and inter-byte timeout.
module receiver_cntrlr
  import receiver_cntrlr_pkg::*;
#(
  parameter int WORD_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_W-1:0]            RX_data,
  input  logic                         RX_done,
  input  logic                         input_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] input_data,
  output logic                         input_valid,
  output logic                         overrun,
  output logic                         timeout
);
  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int CW     = $clog2(WORD_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  rx_state_e         ps;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] asm_reg;
  logic [WORD_W-1:0] asm_with;
  logic              xfer;
  logic              out_free;
  logic              expired;

  assign xfer     = input_valid && input_ready;
  assign out_free = !input_valid || xfer;

  // Assembly register with the incoming byte dropped into slot `count`.
  always_comb begin
    asm_with = asm_reg;
    for (int k = 0; k < WORD_BYTES; k++)
      if (count == CW'(k)) asm_with[k*BYTE_W +: BYTE_W] = RX_data;
  end

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    ((ps != COLLECT) || RX_done || expired),
    .en     ((ps == COLLECT) && !RX_done),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ps          <= IDLE;
      count       <= '0;
      asm_reg     <= '0;
      input_data  <= '0;
      input_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (xfer) input_valid <= 1'b0;
      case (ps)
        IDLE, COLLECT: begin
          if (RX_done) begin
            if (count == LAST) begin
              count <= '0;
              if (out_free) begin
                input_data  <= asm_with;
                input_valid <= 1'b1;
                ps          <= IDLE;
              end else begin
                asm_reg <= asm_with;
                ps      <= STALL;
              end
            end else begin
              asm_reg <= asm_with;
              count   <= count + CW'(1);
              ps      <= COLLECT;
            end
          end else if (ps == COLLECT && expired) begin
            count   <= '0;
            asm_reg <= '0;
            timeout <= 1'b1;
            ps      <= IDLE;
          end
        end
        STALL: begin
          if (xfer) begin
            input_data  <= asm_reg;
            input_valid <= 1'b1;
            if (RX_done) begin
              // Buffer slot frees on this edge, so the new byte starts the next word.
              asm_reg <= asm_with;
              if (LAST == '0) begin
                ps <= STALL;
              end else begin
                count <= CW'(1);
                ps    <= COLLECT;
              end
            end else begin
              ps <= IDLE;
            end
          end else if (RX_done) begin
            overrun <= 1'b1;
          end
        end
        default: ps <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_receiver_cntrlr.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_receiver_cntrlr;
  localparam int WB = 2;
  localparam int T  = 10;
  localparam int DW = 8 * WB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    RX_data = '0;
  logic          RX_done = 1'b0;
  logic          input_ready = 1'b0;
  logic [DW-1:0] input_data;
  logic          input_valid, overrun, timeout;

  int compared = 0;
  int mismatched = 0;

  // Reference model: completed words waiting for the core (front = visible,
  // at most two: output register + stall buffer), bytes of the word in progress.
  logic [DW-1:0] words[$];
  logic [7:0]    part[$];
  int            idle = 0;
  logic [DW-1:0] m_last = '0;
  logic          m_ovr = 1'b0, m_to = 1'b0;

  receiver_cntrlr #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_data    (RX_data),
    .RX_done    (RX_done),
    .input_ready(input_ready),
    .input_data (input_data),
    .input_valid(input_valid),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic d, input logic [7:0] b, input logic rdy);
    logic was_full, xf;
    logic [DW-1:0] w;
    m_ovr = 1'b0;
    m_to  = 1'b0;
    if (!r) begin
      words.delete(); part.delete(); idle = 0; m_last = '0;
      return;
    end
    xf       = (words.size() > 0) && rdy;
    was_full = (words.size() == 2);
    if (xf) m_last = words.pop_front();
    if (d) begin
      if (was_full && !xf) m_ovr = 1'b1;
      else begin
        part.push_back(b);
        idle = 0;
        if (part.size() == WB) begin
          w = '0;
          for (int k = 0; k < WB; k++) w[k*8 +: 8] = part[k];
          part.delete();
          words.push_back(w);
        end
      end
    end else if (part.size() > 0) begin
      idle++;
      if (idle == T + 1) begin
        part.delete(); idle = 0; m_to = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic d, input logic [7:0] b, input logic rdy);
    rst = r; RX_done = d; RX_data = b; input_ready = rdy;
    @(posedge clk);
    model_edge(r, d, b, rdy);
    #1;
    RX_done = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 8'h99, 1'b0);
    compared++;
    if ({input_valid, input_data, overrun, timeout} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b d=%h ovr=%b to=%b, want all 0",
               input_valid, input_data, overrun, timeout);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_basic_word();
    tick(1'b1, 1'b1, 8'h34, 1'b1);
    compared++;
    if (input_valid !== 1'b0) begin
      mismatched++; $display("FAIL basic_first_byte: got v=%b, want v=0", input_valid);
    end
    tick(1'b1, 1'b1, 8'h12, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h1234) begin
      mismatched++; $display("FAIL basic_word: got v=%b d=%h, want v=1 d=1234", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    compared++;
    if (input_valid !== 1'b0) begin
      mismatched++; $display("FAIL basic_one_cycle: got v=%b, want v=0", input_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic saw_ovr = 1'b0;
    logic [7:0] seq[4] = '{8'hCD, 8'hAB, 8'h01, 8'h02};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, seq[i], 1'b0);
      saw_ovr |= overrun;
    end
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'hABCD) begin
      mismatched++; $display("FAIL bp_hold: got v=%b d=%h, want v=1 d=abcd", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    saw_ovr |= overrun;
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h0201) begin
      mismatched++; $display("FAIL bp_second: got v=%b d=%h, want v=1 d=0201", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    saw_ovr |= overrun;
    compared++;
    if (input_valid !== 1'b0 || saw_ovr !== 1'b0) begin
      mismatched++; $display("FAIL bp_drain: got v=%b ovr_seen=%b, want v=0 ovr_seen=0", input_valid, saw_ovr);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] seq[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, seq[i], 1'b0);
    tick(1'b1, 1'b1, 8'h55, 1'b0);
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++; $display("FAIL overrun_pulse: got ovr=%b, want 1", overrun);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    compared++;
    if (overrun !== 1'b0 || input_data !== 16'h0201) begin
      mismatched++; $display("FAIL overrun_single: got ovr=%b d=%h, want ovr=0 d=0201", overrun, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h0403) begin
      mismatched++; $display("FAIL overrun_buffered: got v=%b d=%h, want v=1 d=0403", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'h11, 1'b1);
    tick(1'b1, 1'b1, 8'h22, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h2211) begin
      mismatched++; $display("FAIL overrun_recover: got v=%b d=%h, want v=1 d=2211", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    tick(1'b1, 1'b1, 8'h77, 1'b1);
    for (int k = 1; k <= T + 2; k++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      compared++;
      if (timeout !== (k == T + 1) || input_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_idle%0d: got to=%b v=%b, want to=%b v=0", k, timeout, input_valid, (k == T + 1));
      end
    end
    tick(1'b1, 1'b1, 8'h88, 1'b1);
    tick(1'b1, 1'b1, 8'h99, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h9988) begin
      mismatched++; $display("FAIL timeout_recover: got v=%b d=%h, want v=1 d=9988", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_boundary();
    logic saw_to = 1'b0;
    tick(1'b1, 1'b1, 8'hAA, 1'b1);
    for (int k = 0; k < T; k++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      saw_to |= timeout;
    end
    tick(1'b1, 1'b1, 8'hBB, 1'b1);
    saw_to |= timeout;
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'hBBAA || saw_to !== 1'b0) begin
      mismatched++;
      $display("FAIL expiry_edge_byte: got v=%b d=%h to_seen=%b, want v=1 d=bbaa to_seen=0",
               input_valid, input_data, saw_to);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'h01, 1'b0);
    tick(1'b1, 1'b1, 8'h02, 1'b0);
    tick(1'b1, 1'b1, 8'h03, 1'b0);
    tick(1'b1, 1'b1, 8'h04, 1'b0);
    tick(1'b1, 1'b1, 8'h5A, 1'b1);
    compared++;
    if (overrun !== 1'b0 || input_valid !== 1'b1 || input_data !== 16'h0403) begin
      mismatched++;
      $display("FAIL stall_xfer_rx: got ovr=%b v=%b d=%h, want ovr=0 v=1 d=0403", overrun, input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'hA5, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'hA55A) begin
      mismatched++; $display("FAIL stall_byte_lsb: got v=%b d=%h, want v=1 d=a55a", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_word();
    tick(1'b1, 1'b1, 8'h42, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    compared++;
    if ({input_valid, input_data, overrun, timeout} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got v=%b d=%h ovr=%b to=%b, want all 0",
               input_valid, input_data, overrun, timeout);
    end
    tick(1'b1, 1'b1, 8'h01, 1'b1);
    tick(1'b1, 1'b1, 8'h00, 1'b1);
    compared++;
    if (input_valid !== 1'b1 || input_data !== 16'h0001) begin
      mismatched++; $display("FAIL reset_mid_word: got v=%b d=%h, want v=1 d=0001", input_valid, input_data);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int rx_div = 2, rdy_pct = 50;
    logic r, d, rdy, ev;
    logic [DW-1:0] ed;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) begin
        rx_div  = (cyc % 600 == 0) ? 2 : ((cyc % 600 == 200) ? 7 : 16);
        rdy_pct = $urandom_range(10, 100);
      end
      r   = ($urandom_range(0, 699) != 0);
      d   = ($urandom_range(0, rx_div - 1) == 0);
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      tick(r, d, 8'($urandom), rdy);
      ev = (words.size() > 0);
      ed = ev ? words[0] : m_last;
      compared++;
      if (input_valid !== ev || input_data !== ed || overrun !== m_ovr || timeout !== m_to) begin
        mismatched++;
        $display("FAIL random_cyc%0d: got v=%b d=%h ovr=%b to=%b, want v=%b d=%h ovr=%b to=%b",
                 cyc, input_valid, input_data, overrun, timeout, ev, ed, m_ovr, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_back_pressure();
    test_overrun();
    test_timeout();
    test_boundary();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
